// File: rtl/gray_pkg.sv
// Shared definitions for the 3x3 RGB444 grayscale window scheduler.
//   state_t : scheduler states. IDLE waits for a window, ROW0..ROW2 convert one
//             window row per cycle, and DONE presents the result.
//   COEF_*  : luma weights. They sum to 256, so dividing the sum by 2 yields a
//             12-bit gray word no larger than 0x780.
//   WIN_N   : pixels per window.
//   ROW_N   : pixels per row, which is also the number of shared lanes.
package gray_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW0 = 3'd1,
    ROW1 = 3'd2,
    ROW2 = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;
  localparam int WIN_N  = 9;
  localparam int ROW_N  = 3;

endpackage

// File: rtl/gray_lane.sv
// One combinational grayscale lane.
//   pix  : RGB444 pixel, with R in [11:8], G in [7:4] and B in [3:0].
//   en   : 1 converts the pixel to gray, 0 passes it through unchanged.
//   gray : gray word, zero-extended to PIX_W, or the unchanged pixel.
module gray_lane
  import gray_pkg::*;
#(
  parameter int PIX_W = 12
) (
  input  logic [PIX_W-1:0] pix,
  input  logic             en,
  output logic [PIX_W-1:0] gray
);

  // The weighted sum fits in 13 bits (15*256 = 3840).
  // Halving the sum keeps the upper 12 bits of that 13-bit value.
  function automatic logic [PIX_W-1:0] scale_sum(input logic [12:0] s);
    return PIX_W'(s >> 1);
  endfunction

  logic [12:0] r_term;
  logic [12:0] g_term;
  logic [12:0] b_term;
  logic [12:0] sum;

  always_comb begin
    r_term = 13'(pix[11:8]) * 13'(COEF_R);
    g_term = 13'(pix[7:4])  * 13'(COEF_G);
    b_term = 13'(pix[3:0])  * 13'(COEF_B);
    sum    = r_term + g_term + b_term;
    gray   = en ? scale_sum(sum) : pix;
  end

endmodule

// File: rtl/gray_window_sched.sv
// Scheduler that shares three grayscale lanes across a 3x3 RGB444 window.
// A captured window is converted one row per cycle in ROW0..ROW2. The result is
// then presented in DONE until the downstream handshake completes.
//   clk, reset_n : clock and asynchronous active-low reset.
//   in_valid     : upstream valid.
//   in_ready     : upstream ready.
//   in_data      : 9-pixel window. Pixel p occupies [PIX_W*p +: PIX_W].
//   cfg_gray_en  : 1 converts the window, 0 bypasses it. Sampled on accept.
//   out_valid    : downstream valid.
//   out_ready    : downstream ready.
//   out_data     : result window, packed the same way as in_data.
//   busy         : high while a row is being converted.
//   win_cnt      : completed output handshakes. Wraps at 2^CNT_W.
module gray_window_sched
  import gray_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIN_N*PIX_W-1:0] in_data,
  input  logic                   cfg_gray_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIN_N*PIX_W-1:0] out_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       win_cnt
);

  state_t                 state;
  state_t                 nxt;
  logic [1:0]             row_sel;
  logic                   accept;
  logic [WIN_N*PIX_W-1:0] win_p0;
  logic                   en_p0;
  logic [WIN_N*PIX_W-1:0] out_p1;
  logic [CNT_W-1:0]       cnt;
  logic [PIX_W-1:0]       lane_pix [ROW_N];
  logic [PIX_W-1:0]       lane_out [ROW_N];

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    row_sel   = 2'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = ROW0;
      end
      ROW0: begin
        busy    = 1'b1;
        row_sel = 2'd0;
        nxt     = ROW1;
      end
      ROW1: begin
        busy    = 1'b1;
        row_sel = 2'd1;
        nxt     = ROW2;
      end
      ROW2: begin
        busy    = 1'b1;
        row_sel = 2'd2;
        nxt     = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Passing out_ready straight through lets the next window be accepted
        // on the same edge that retires the current one.
        in_ready  = out_ready;
        if (out_ready) nxt = in_valid ? ROW0 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Stage p0: captured window and enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_p0 <= '0;
      en_p0  <= 1'b0;
    end else if (accept) begin
      win_p0 <= in_data;
      en_p0  <= cfg_gray_en;
    end
  end

  for (genvar k = 0; k < ROW_N; k++) begin : g_lane
    assign lane_pix[k] = win_p0[PIX_W*(ROW_N*int'(row_sel)+k) +: PIX_W];

    gray_lane #(.PIX_W(PIX_W)) u_lane (
      .pix  (lane_pix[k]),
      .en   (en_p0),
      .gray (lane_out[k])
    );
  end

  // Stage p1: result window. Only the row selected by the current state is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_p1 <= '0;
    end else if (busy) begin
      for (int k = 0; k < ROW_N; k++)
        out_p1[PIX_W*(ROW_N*int'(row_sel)+k) +: PIX_W] <= lane_out[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   cnt <= '0;
    else if (out_valid & out_ready) cnt <= cnt + 1'b1;
  end

  assign out_data = out_p1;
  assign win_cnt  = cnt;

endmodule

// File: tb/tb_gray_window_sched.sv
module tb_gray_window_sched;

  localparam int PIX_W = 12;
  localparam int W     = 9 * PIX_W;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         cfg_gray_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic [15:0]  win_cnt;

  logic         in_ready2;
  logic         out_valid2;
  logic [W-1:0] out_data2;
  logic         busy2;
  logic [1:0]   win_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_window_sched #(.PIX_W(PIX_W), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_gray_en(cfg_gray_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .win_cnt(win_cnt)
  );

  gray_window_sched #(.PIX_W(PIX_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .cfg_gray_en(cfg_gray_en), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .busy(busy2), .win_cnt(win_cnt2)
  );

  typedef struct {
    logic [W-1:0] win;
    logic         en;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[11];

  // Reference model: luma formula applied to each pixel independently.
  function automatic logic [W-1:0] ref_win(input logic [W-1:0] w, input logic en);
    logic [W-1:0] r;
    int p, rr, gg, bb;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      p  = int'(w[12*i +: 12]);
      rr = (p >> 8) & 15;
      gg = (p >> 4) & 15;
      bb = p & 15;
      if (en) r[12*i +: 12] = 12'((rr * 77 + gg * 150 + bb * 29) / 2);
      else    r[12*i +: 12] = w[12*i +: 12];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_win();
    logic [W-1:0] w;
    for (int i = 0; i < 9; i++) w[12*i +: 12] = 12'($urandom);
    return w;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Sends one window with out_ready already set by the caller, flips
  // cfg_gray_en while the window is in flight, and returns once out_valid
  // is observed.
  task automatic run_window(input logic [W-1:0] w, input logic en,
                            input logic [W-1:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    in_data     = w;
    cfg_gray_en = en;
    in_valid    = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " accept_ready"}, W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~w;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) cfg_gray_en = ~en;
    end while (!out_valid && cyc < 20);
    check({nm, " latency"}, W'(cyc), W'(4));
    check({nm, " data"}, out_data, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w, w2, e, e2;
    logic [W-1:0] sw[5];
    logic         se[5];
    logic [W-1:0] q[$];
    int c0, idx, nout, last_out;
    logic acc;

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_gray_en = 1'b0;
    out_ready   = 1'b1;

    #12;
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst busy", W'(busy), W'(0));
    check("rst win_cnt", W'(win_cnt), W'(0));
    check("rst out_data", out_data, '0);
    reset_n = 1'b1;

    vecs[0] = '{win: {9{12'hFFF}}, en: 1'b1, exp: {9{12'h780}}, name: "white"};
    vecs[1] = '{win: {12'h000, 12'h00F, 12'h0F0, 12'hF00, 12'hFFF, 12'h000, 12'h00F, 12'h0F0, 12'hF00},
                en: 1'b1,
                exp: {12'h000, 12'h0D9, 12'h465, 12'h241, 12'h780, 12'h000, 12'h0D9, 12'h465, 12'h241},
                name: "primaries"};
    vecs[2] = '{win: {12'h000, 12'h00F, 12'h0F0, 12'hF00, 12'hFFF, 12'h000, 12'h00F, 12'h0F0, 12'hF00},
                en: 1'b0,
                exp: {12'h000, 12'h00F, 12'h0F0, 12'hF00, 12'hFFF, 12'h000, 12'h00F, 12'h0F0, 12'hF00},
                name: "bypass"};
    for (int i = 3; i < 11; i++) begin
      w = rand_win();
      vecs[i].win  = w;
      vecs[i].en   = 1'($urandom);
      vecs[i].exp  = ref_win(w, vecs[i].en);
      vecs[i].name = $sformatf("rand%0d", i);
    end

    for (int i = 0; i < 11; i++)
      run_window(vecs[i].win, vecs[i].en, vecs[i].exp, vecs[i].name);
    @(negedge clk);
    check("table win_cnt", W'(win_cnt), W'(11));
    check("table win_cnt cnt2", W'(win_cnt2), W'(3));

    // Backpressure while a second window waits upstream.
    c0 = int'(win_cnt);
    out_ready = 1'b0;
    w  = rand_win();
    e  = ref_win(w, 1'b1);
    run_window(w, 1'b1, e, "bp first");
    w2 = rand_win();
    e2 = ref_win(w2, 1'b0);
    in_data     = w2;
    cfg_gray_en = 1'b0;
    in_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp hold valid %0d", i), W'(out_valid), W'(1));
      check($sformatf("bp hold in_ready %0d", i), W'(in_ready), W'(0));
      check($sformatf("bp hold busy %0d", i), W'(busy), W'(0));
      check($sformatf("bp hold data %0d", i), out_data, e);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    cfg_gray_en = 1'b1;
    idx = 0;
    do begin
      @(negedge clk);
      idx++;
    end while (!out_valid && idx < 20);
    check("bp second latency", W'(idx), W'(4));
    check("bp second data", out_data, e2);
    @(negedge clk);
    check("bp win_cnt", W'(win_cnt), W'(c0 + 2));

    // Reset asserted in ROW1 takes effect before any clock edge.
    @(negedge clk);
    in_data     = rand_win();
    cfg_gray_en = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid busy", W'(busy), W'(1));
    #1 reset_n = 1'b0;
    #1;
    check("mid rst out_valid", W'(out_valid), W'(0));
    check("mid rst in_ready", W'(in_ready), W'(1));
    check("mid rst busy", W'(busy), W'(0));
    check("mid rst win_cnt", W'(win_cnt), W'(0));
    check("mid rst out_data", out_data, '0);
    #1 reset_n = 1'b1;
    w = rand_win();
    run_window(w, 1'b1, ref_win(w, 1'b1), "post rst");
    @(negedge clk);
    check("post rst win_cnt", W'(win_cnt), W'(1));

    // Back-to-back stream of five windows with both sides always ready.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      sw[i] = rand_win();
      se[i] = 1'($urandom);
    end
    idx = 0;
    nout = 0;
    last_out = -1;
    @(negedge clk);
    in_data     = sw[0];
    cfg_gray_en = se[0];
    in_valid    = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (q.size() > 0) check($sformatf("stream data %0d", nout), out_data, q.pop_front());
        else check($sformatf("stream unexpected out %0d", nout), W'(out_valid), W'(0));
        if (last_out >= 0) check($sformatf("stream gap %0d", nout), W'(cyc - last_out), W'(4));
        last_out = cyc;
        nout++;
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(ref_win(sw[idx], se[idx]));
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 5) begin
          in_data     = sw[idx];
          cfg_gray_en = se[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream outputs", W'(nout), W'(5));
    @(negedge clk);
    check("stream win_cnt", W'(win_cnt), W'(5));
    check("stream win_cnt cnt2 wrap", W'(win_cnt2), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_window_sched.md
Name: gray_window_sched

Overview:
- Controller that time-multiplexes three shared grayscale lanes across the nine pixels of a 3x3 RGB444 window. The window is processed one row per cycle.
- Sits between the 3x3 line-buffer window generator and downstream window filters (Sobel/median).
- Valid/ready handshake on both sides, so upstream and downstream can stall independently.
- Per-window bypass and a completed-window counter for debug.

Parameters:
- PIX_W, 12, bits per pixel (RGB444 in, gray word out).
- CNT_W, 16, width of the completed-window counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream window valid.
- in_ready  out  1  block can accept a window this cycle.
- in_data  in  9*PIX_W  window; pixel p = row*3+col occupies bits [PIX_W*p+PIX_W-1 : PIX_W*p]; each pixel is R[11:8] G[7:4] B[3:0].
- cfg_gray_en  in  1  1 = convert, 0 = bypass; sampled on input handshake.
- out_valid  out  1  result window valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  9*PIX_W  result window, same pixel packing as in_data.
- busy  out  1  high in ROW0/ROW1/ROW2.
- win_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, win_cnt=0, captured window and captured enable cleared.
- Reset mid-operation aborts the window with no output. It takes effect immediately, without waiting for a clock edge.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data and cfg_gray_en, then go to ROW0.
  - ROW0: the three lanes take captured pixels 0,1,2; results are written into out_data row 0 at the edge. Go to ROW1.
  - ROW1: pixels 3,4,5 into row 1. Go to ROW2.
  - ROW2: pixels 6,7,8 into row 2. Go to DONE.
  - DONE: out_valid=1; out_data is held stable until handshake.
    - out_valid&out_ready with in_valid=1: accept the new window in the same cycle (in_ready=out_ready in DONE) and go to ROW0.
    - out_valid&out_ready with in_valid=0: go to IDLE.
    - out_ready=0: stay in DONE and hold. in_ready=0, so upstream stalls.
- Latency and throughput:
  - Accept handshake at edge E; out_valid rises after edge E+3.
  - Sustained throughput is one window per 4 cycles when downstream is always ready.
- ROWx states ignore in_valid/out_ready; in_ready=0 there.
- Lane arithmetic, unsigned:
  - sum = R*77 + G*150 + B*29, 13 bits, maximum 3840, no overflow.
  - gray = sum[12:1], zero-extended to 12 bits, maximum 0x780.
- Bypass (captured enable=0): lane output = lane input pixel unchanged. Latency and handshake are identical to convert mode.
- Changing cfg_gray_en while a window is in flight has no effect on that window.
- win_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- out_data rows are updated only in their ROW state; rows not yet rewritten keep the previous window's values. out_data is only meaningful while out_valid=1.

Decomposition:
- Package gray_pkg:
  - enum state_t {IDLE, ROW0, ROW1, ROW2, DONE}.
  - localparams COEF_R=77, COEF_G=150, COEF_B=29, WIN_N=9, ROW_N=3.
- Sub-module gray_lane: combinational, one RGB444 pixel plus enable in, one 12-bit word out. Instantiated 3 times.
- All sequencing, capture registers and the counter live in gray_window_sched.

Test Plan:
1. Single window, out_ready=1, all nine pixels 0xFFF, enable=1 -> out_valid rises 4th cycle after accept; every pixel 0x780; win_cnt=1.
2. Pixels 0..8 = 0xF00,0x0F0,0x00F,0x000,0xFFF,0xF00,0x0F0,0x00F,0x000, enable=1 -> out 0x241,0x465,0x0D9,0x000,0x780,0x241,0x465,0x0D9,0x000.
3. Same window with enable=0, and enable toggled to 1 during ROW1 -> out_data equals in_data exactly.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, state DONE. On out_ready=1 with in_valid=1, next window accepted in the same cycle; its out_valid rises 4 cycles later.
5. Back-to-back stream of 5 windows, both sides always ready -> one output every 4 cycles; win_cnt=5. With CNT_W forced to 2, win_cnt reads 1 after 5 windows.
6. reset_n pulsed low during ROW1 -> out_valid=0, in_ready=1, win_cnt=0 immediately. Next window processes correctly.
